cstn_pattern_src: RTL

//  Pixel source that feeds the CSTN display controller's 48-bit line FIFO on the write side.

---
 rtl/cstn_pkg.sv | 31 +++
 rtl/cstn_pattern_src_if.sv | 17 +
 rtl/cstn_req_sync.sv | 48 ++++
 rtl/cstn_pattern_src.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/cstn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cstn_pkg
//  Description : Shared encodings and word geometry for the CSTN pattern source.
//  Revision    : 1.0 - initial release
// ============================================================================
package cstn_pkg;

    localparam int PIX_BITS     = 3;
    localparam int PIX_PER_WORD = 16;
    localparam int WORD_BITS    = PIX_BITS * PIX_PER_WORD;

    localparam logic [2:0] MODE_SOLID = 3'd0;
    localparam logic [2:0] MODE_VBARS = 3'd1;
    localparam logic [2:0] MODE_HBARS = 3'd2;
    localparam logic [2:0] MODE_CHECK = 3'd3;
    localparam logic [2:0] MODE_CYCLE = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Every pixel of a word carries the same colour.
    function automatic logic [WORD_BITS-1:0] rep_color(input logic [PIX_BITS-1:0] c);
        return {PIX_PER_WORD{c}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cstn_pattern_src_if.sv
`default_nettype none
// ============================================================================
//  Module      : cstn_pattern_src_if
//  Description : Write side of the CSTN controller's 48-bit line FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cstn_pattern_src_if;
    import cstn_pkg::*;

    logic                 fifo_full;
    logic                 fifo_wr_en;
    logic [WORD_BITS-1:0] fifo_wr_data;

    modport master (input fifo_full, output fifo_wr_en, output fifo_wr_data);
    modport slave  (output fifo_full, input fifo_wr_en, input fifo_wr_data);
endinterface
`default_nettype wire

// File: rtl/cstn_req_sync.sv
`default_nettype none
// ============================================================================
//  Module      : cstn_req_sync
//  Description : Frame request rising-edge detector; with CSTN_SRC_FRAME_SYNC_EN
//                defined, frame_req first passes a 2-flop synchronizer.
//  Revision    : 1.0 - initial release
// ============================================================================
module cstn_req_sync (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic frame_req,
    output logic      req_pulse
);

    logic w_req_s;
    logic r_req_q;
    logic r_pulse;

`ifdef CSTN_SRC_FRAME_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], frame_req};
        end
    end

    assign w_req_s = r_sync[1];
`else
    assign w_req_s = frame_req;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_q <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_req_q <= w_req_s;
            r_pulse <= w_req_s & ~r_req_q;
        end
    end

    assign req_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/cstn_pattern_src.sv
`default_nettype none
// ============================================================================
//  Module      : cstn_pattern_src
//  Description : Test-pattern frame generator feeding the CSTN line FIFO.
//                Optional frame_req synchronizer: CSTN_SRC_FRAME_SYNC_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module cstn_pattern_src
    import cstn_pkg::*;
#(
    parameter int H_PIXELS     = 640,
    parameter int V_LINES      = 480,
    parameter int CYCLE_FRAMES = 256
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic [2:0]          mode,
    input  wire logic [2:0]          solid_color,
    input  wire logic                frame_req,
    cstn_pattern_src_if.master       fifo,
    output logic                     busy,
    output logic                     overrun,
    output logic [7:0]               frame_cnt
);

    localparam int c_h_words = H_PIXELS / PIX_PER_WORD;
    localparam int c_x_w     = $clog2(c_h_words);
    localparam int c_y_w     = $clog2(V_LINES);

    localparam logic [c_x_w-1:0] c_x_max   = c_x_w'(c_h_words - 1);
    localparam logic [c_y_w-1:0] c_y_max   = c_y_w'(V_LINES - 1);
    localparam logic [c_x_w-1:0] c_x_bar   = c_x_w'(c_h_words / 8);
    localparam logic [c_y_w-1:0] c_y_bar   = c_y_w'(V_LINES / 8);
    localparam logic [7:0]       c_cyc_msk = 8'(CYCLE_FRAMES - 1);

    state_e               r_state;
    state_e               w_state_nxt;
    logic [c_x_w-1:0]     r_x;
    logic [c_y_w-1:0]     r_y;
    logic [2:0]           r_mode;
    logic [2:0]           r_solid;
    logic [2:0]           r_cyc;
    logic [7:0]           r_frame_cnt;
    logic                 r_overrun;

    logic                 w_req_pulse;
    logic                 w_start;
    logic                 w_wr_en;
    logic                 w_last;
    logic                 w_x_last;
    logic                 w_y_last;
    logic                 w_y4;
    logic [c_x_w-1:0]     w_xdiv;
    logic [c_y_w-1:0]     w_ydiv;
    logic [7:0]           w_cnt_inc;
    logic [2:0]           w_color;
    logic [WORD_BITS-1:0] w_data;

    cstn_req_sync u_req_sync (
        .clk       (clk),
        .rst       (rst),
        .frame_req (frame_req),
        .req_pulse (w_req_pulse)
    );

    assign w_x_last  = (r_x == c_x_max);
    assign w_y_last  = (r_y == c_y_max);
    assign w_cnt_inc = r_frame_cnt + 8'd1;
    assign w_xdiv    = r_x / c_x_bar;
    assign w_ydiv    = r_y / c_y_bar;

    // Checkerboard squares are 16 lines tall; short frames never reach y[4].
    generate
        if (c_y_w > 4) begin : g_y4
            assign w_y4 = r_y[4];
        end else begin : g_y4_none
            assign w_y4 = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_wr_en     = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req_pulse) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                w_wr_en = ~fifo.fifo_full;
                if (w_wr_en && w_x_last && w_y_last) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x         <= '0;
            r_y         <= '0;
            r_mode      <= MODE_SOLID;
            r_solid     <= 3'd0;
            r_cyc       <= 3'd0;
            r_frame_cnt <= 8'd0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_start) begin
                r_mode  <= mode;
                r_solid <= solid_color;
                r_x     <= '0;
                r_y     <= '0;
            end else if (w_wr_en) begin
                if (w_x_last) begin
                    r_x <= '0;
                    r_y <= w_y_last ? '0 : r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end
            // The colour step lands on the frame that brings the count to a multiple of CYCLE_FRAMES.
            if (w_last) begin
                r_frame_cnt <= w_cnt_inc;
                if ((w_cnt_inc & c_cyc_msk) == 8'd0) begin
                    r_cyc <= r_cyc + 3'd1;
                end
            end
            if (w_req_pulse && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    always_comb begin
        w_color = 3'd0;
        case (r_mode)
            MODE_SOLID: w_color = r_solid;
            MODE_VBARS: w_color = 3'd7 - w_xdiv[2:0];
            MODE_HBARS: w_color = 3'd7 - w_ydiv[2:0];
            MODE_CHECK: w_color = (r_x[0] ^ w_y4) ? 3'b111 : 3'b000;
            MODE_CYCLE: w_color = r_cyc;
            default:    w_color = 3'd0;
        endcase
        w_data = (r_state == ST_FILL) ? rep_color(w_color) : '0;
    end

    assign fifo.fifo_wr_en   = w_wr_en;
    assign fifo.fifo_wr_data = w_data;
    assign busy              = (r_state == ST_FILL);
    assign overrun           = r_overrun;
    assign frame_cnt         = r_frame_cnt;

endmodule
`default_nettype wire
